// File: rtl/mode_controller.sv
// Mode sequencer for the digital clock: debounces MODE/RUN keys, owns the one-hot
// datapath enables and blinks done_led once a countdown has expired.

module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic press
);
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;

   // Synchronize, then accept a level change only after it has been stable long enough
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync2;
            press <= ~sync2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

module mode_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 270000,
   parameter int unsigned BLINK_CYCLES    = 13500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_mode,
   input  logic       key_run,
   input  logic       cnt_zero,
   output logic       enaclk,
   output logic       enaset,
   output logic       enastp,
   output logic       enactd,
   output logic [1:0] mode,
   output logic       done_led
);
   localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);

   typedef enum logic [2:0] {
      S_CLK      = 3'd0,
      S_SET      = 3'd1,
      S_STP_HOLD = 3'd2,
      S_STP_RUN  = 3'd3,
      S_CTD_HOLD = 3'd4,
      S_CTD_RUN  = 3'd5,
      S_CTD_DONE = 3'd6
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [1:0]    mode_next;
   logic          p_mode;
   logic          p_run;
   logic [BW-1:0] blink_cnt;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
      .clk   (clk),
      .rst   (rst),
      .key   (key_mode),
      .press (p_mode)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_run (
      .clk   (clk),
      .rst   (rst),
      .key   (key_run),
      .press (p_run)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_CLK;
      else     state <= state_next;
   end

   // p_mode beats everything; countdown expiry beats p_run
   always_comb begin
      state_next = state;
      mode_next  = 2'd0;
      case (state)
         S_CLK:      if (p_mode) state_next = S_SET;
         S_SET:      if (p_mode) state_next = S_STP_HOLD;
         S_STP_HOLD: if (p_mode)     state_next = S_CTD_HOLD;
                     else if (p_run) state_next = S_STP_RUN;
         S_STP_RUN:  if (p_mode)     state_next = S_CTD_HOLD;
                     else if (p_run) state_next = S_STP_HOLD;
         S_CTD_HOLD: if (p_mode)                  state_next = S_CLK;
                     else if (p_run && !cnt_zero) state_next = S_CTD_RUN;
         S_CTD_RUN:  if (p_mode)        state_next = S_CLK;
                     else if (cnt_zero) state_next = S_CTD_DONE;
                     else if (p_run)    state_next = S_CTD_HOLD;
         S_CTD_DONE: if (p_mode)     state_next = S_CLK;
                     else if (p_run) state_next = S_CTD_HOLD;
         default:    state_next = S_CLK;
      endcase
      case (state_next)
         S_SET:                              mode_next = 2'd1;
         S_STP_HOLD, S_STP_RUN:              mode_next = 2'd2;
         S_CTD_HOLD, S_CTD_RUN, S_CTD_DONE:  mode_next = 2'd3;
         default:                            mode_next = 2'd0;
      endcase
   end

   // Outputs registered from the next state so they track the state register exactly
   always_ff @(posedge clk) begin
      if (rst) begin
         enaclk <= 1'b1;
         enaset <= 1'b0;
         enastp <= 1'b0;
         enactd <= 1'b0;
         mode   <= 2'd0;
      end else begin
         enaclk <= (state_next == S_CLK);
         enaset <= (state_next == S_SET);
         enastp <= (state_next == S_STP_RUN);
         enactd <= (state_next == S_CTD_RUN);
         mode   <= mode_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
         done_led  <= 1'b0;
      end else if (state_next != S_CTD_DONE) begin
         blink_cnt <= '0;
         done_led  <= 1'b0;
      end else if (state != S_CTD_DONE) begin
         blink_cnt <= '0;
         done_led  <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
         blink_cnt <= '0;
         done_led  <= ~done_led;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end
endmodule

// File: tb/tb_mode_controller.sv
// Scoreboard bench for mode_controller: a mode/run/done reference model predicts
// every cycle's outputs; a monitor compares them against the DUT.

module tb_mode_controller;
   localparam int unsigned DEB = 4;
   localparam int unsigned BLK = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_mode;
   logic       key_run;
   logic       cnt_zero;
   logic       enaclk;
   logic       enaset;
   logic       enastp;
   logic       enactd;
   logic [1:0] mode;
   logic       done_led;

   typedef struct packed {
      logic       enaclk;
      logic       enaset;
      logic       enastp;
      logic       enactd;
      logic [1:0] mode;
      logic       done_led;
   } obs_t;

   obs_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: mode index, running flag, expired flag, cycles spent expired
   int             m_mode;
   bit             m_run;
   bit             m_done;
   int             n_done;
   bit             pend_mode;
   bit             pend_run;
   bit             lvl_mode;
   bit             lvl_run;
   logic [DEB+1:0] hist_mode;
   logic [DEB+1:0] hist_run;

   mode_controller #(.DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLK)) dut (
      .clk      (clk),
      .rst      (rst),
      .key_mode (key_mode),
      .key_run  (key_run),
      .cnt_zero (cnt_zero),
      .enaclk   (enaclk),
      .enaset   (enaset),
      .enastp   (enastp),
      .enactd   (enactd),
      .mode     (mode),
      .done_led (done_led)
   );

   always #5 clk = ~clk;

   // A key level is accepted once the raw samples two to DEB+1 edges old all disagree with it
   task automatic deb_step(inout logic [DEB+1:0] h, inout bit lvl, input bit raw, output bit press);
      bit all_diff;
      all_diff = 1'b1;
      for (int i = 1; i <= int'(DEB); i++)
         if (h[i] == lvl) all_diff = 1'b0;
      press = 1'b0;
      if (all_diff) begin
         press = lvl;
         lvl   = ~lvl;
      end
      h = {h[DEB:0], raw};
   endtask

   task automatic model(input bit r, input bit km, input bit kr, input bit cz, output obs_t e);
      bit prev_done;
      bit led;
      if (r) begin
         m_mode = 0; m_run = 0; m_done = 0; n_done = 0;
         pend_mode = 0; pend_run = 0; lvl_mode = 1; lvl_run = 1;
         hist_mode = '1; hist_run = '1;
         led = 0;
      end else begin
         prev_done = m_done;
         if (pend_mode) begin
            m_mode = (m_mode + 1) % 4;
            m_run  = 0;
            m_done = 0;
         end else if (m_mode == 3 && m_run && cz) begin
            m_run  = 0;
            m_done = 1;
         end else if (pend_run) begin
            if (m_mode == 2) m_run = ~m_run;
            else if (m_mode == 3) begin
               if (m_done)     m_done = 0;
               else if (m_run) m_run = 0;
               else if (!cz)   m_run = 1;
            end
         end
         if (m_done) begin
            n_done = prev_done ? n_done + 1 : 0;
            led    = ((n_done / int'(BLK)) % 2) == 0;
         end else begin
            n_done = 0;
            led    = 0;
         end
         deb_step(hist_mode, lvl_mode, km, pend_mode);
         deb_step(hist_run, lvl_run, kr, pend_run);
      end
      e.enaclk   = (m_mode == 0);
      e.enaset   = (m_mode == 1);
      e.enastp   = (m_mode == 2) && m_run;
      e.enactd   = (m_mode == 3) && m_run;
      e.mode     = 2'(m_mode);
      e.done_led = led;
   endtask

   task automatic step(input bit r, input bit km, input bit kr, input bit cz);
      obs_t e;
      @(negedge clk);
      rst = r; key_mode = km; key_run = kr; cnt_zero = cz;
      @(posedge clk);
      model(r, km, kr, cz, e);
      exp_q.push_back(e);
   endtask

   task automatic hold(input bit km, input bit kr, input bit cz, input int n);
      for (int i = 0; i < n; i++) step(1'b0, km, kr, cz);
   endtask

   task automatic press_key(input bit is_mode, input bit cz);
      hold(~is_mode, is_mode, cz, 8);
      hold(1'b1, 1'b1, cz, 8);
   endtask

   // Monitor: compare DUT outputs just after every edge for which an expectation exists
   initial begin
      obs_t e;
      obs_t got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {enaclk, enaset, enastp, enactd, mode, done_led};
            tests++;
            if (got !== e)begin
               fails++;
               $display("FAIL outputs t=%0t got clk/set/stp/ctd=%b%b%b%b mode=%0d led=%b, expected %b%b%b%b mode=%0d led=%b",
                        $time, got.enaclk, got.enaset, got.enastp, got.enactd, got.mode, got.done_led,
                        e.enaclk, e.enaset, e.enastp, e.enactd, e.mode, e.done_led);
            end
         end
      end
   end

   initial begin
      int t_mode, t_run, t_cz;
      bit km, kr, cz, r;
      step(1, 1, 1, 0);
      step(1, 1, 1, 0);
      hold(1, 1, 0, 4);
      hold(0, 1, 0, 3);                  // short glitch: no press
      hold(1, 1, 0, 10);
      hold(0, 1, 0, 20);                 // long hold: one press -> SET
      hold(1, 1, 0, 10);
      repeat (3) press_key(1, 0);        // STP, CTD, CLK
      repeat (3) press_key(1, 0);        // SET, STP, CTD_HOLD
      press_key(0, 0);                   // CTD_RUN
      hold(1, 1, 1, 30);                 // expire and blink
      press_key(0, 1);                   // DONE -> HOLD
      press_key(0, 1);                   // ignored with cnt_zero
      press_key(1, 0);                   // CLK
      press_key(1, 0);                   // SET
      press_key(0, 0);                   // ignored in SET
      press_key(1, 0);                   // STP_HOLD
      press_key(0, 0);                   // STP_RUN
      hold(0, 0, 0, 8);                  // simultaneous presses -> CTD_HOLD
      hold(1, 1, 0, 8);
      press_key(0, 0);                   // CTD_RUN
      hold(1, 1, 1, 12);                 // DONE
      step(1, 1, 1, 1);                  // reset mid-DONE
      hold(1, 1, 0, 3);

      t_mode = 0; t_run = 0; t_cz = 0;
      km = 1; kr = 1; cz = 0;
      for (int c = 0; c < 3000; c++) begin
         if (t_mode == 0) begin km = ~km; t_mode = $urandom_range(1, 12); end
         if (t_run == 0)  begin kr = ~kr; t_run = $urandom_range(1, 12); end
         if (t_cz == 0)   begin cz = ~cz; t_cz = $urandom_range(1, 40); end
         t_mode--; t_run--; t_cz--;
         r = ($urandom_range(0, 499) == 0);
         step(r, km, kr, cz);
      end

      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
